// File: rtl/alarm_ctrl.sv
// Keypad alarm controller: opens the lock on a correct code, raises the alarm
// after MAX_FAILS consecutive wrong codes, then enforces a lockout period.
// One 27-bit down-counter times every state; all outputs are registered Moore levels.
module alarm_ctrl #(
  parameter int unsigned MAX_FAILS    = 3,
  parameter int unsigned OPEN_CYCLES  = 5_000_000,
  parameter int unsigned ALARM_CYCLES = 50_000_000,
  parameter int unsigned LOCK_CYCLES  = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       check,
  input  logic       match,
  input  logic       close,
  input  logic       admin_clr,
  output logic       unlock,
  output logic       alarm,
  output logic       locked_out,
  output logic [1:0] fail_cnt
);

  localparam int unsigned TimerW = 27;

  // Timer reload values: a state lasting N cycles is entered with N-1 and left on 0.
  localparam logic [TimerW-1:0] OpenLoad  = TimerW'(OPEN_CYCLES - 1);
  localparam logic [TimerW-1:0] AlarmLoad = TimerW'(ALARM_CYCLES - 1);
  localparam logic [TimerW-1:0] LockLoad  = TimerW'(LOCK_CYCLES - 1);

  // Saturation value and a 3-bit copy so fail_cnt+1 can be compared without overflow.
  localparam logic [1:0] MaxFailsCnt = 2'(MAX_FAILS);
  localparam logic [2:0] MaxFailsCmp = 3'(MAX_FAILS);

  typedef enum logic [1:0] {
    StIdle,
    StOpen,
    StAlarm,
    StLockout
  } state_e;

  state_e              state_q, state_d;
  logic   [TimerW-1:0] timer_q, timer_d;
  logic   [1:0]        fail_q, fail_d;
  logic                unlock_q, unlock_d;
  logic                alarm_q, alarm_d;
  logic                locked_q, locked_d;

  logic                timer_zero;
  logic   [TimerW-1:0] timer_dec;
  logic   [2:0]        fail_inc;

  assign timer_zero = (timer_q == '0);
  assign timer_dec  = timer_q - TimerW'(1);
  assign fail_inc   = {1'b0, fail_q} + 3'd1;

  // Next state, timer and failure count; priority admin_clr > expiry > close > check.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    fail_d  = fail_q;

    unique case (state_q)
      StIdle: begin
        if (admin_clr) begin
          // Administrator clear wins over a code submitted in the same cycle.
          fail_d = '0;
        end else if (check) begin
          if (match) begin
            state_d = StOpen;
            timer_d = OpenLoad;
            fail_d  = '0;
          end else if (fail_inc < MaxFailsCmp) begin
            fail_d = fail_inc[1:0];
          end else begin
            state_d = StAlarm;
            timer_d = AlarmLoad;
            fail_d  = MaxFailsCnt;
          end
        end
      end

      StOpen: begin
        // admin_clr and check have no effect while the door is open.
        if (timer_zero) begin
          state_d = StIdle;
        end else if (close) begin
          state_d = StIdle;
          timer_d = '0;
        end else begin
          timer_d = timer_dec;
        end
      end

      StAlarm: begin
        if (admin_clr) begin
          state_d = StIdle;
          timer_d = '0;
          fail_d  = '0;
        end else if (timer_zero) begin
          state_d = StLockout;
          timer_d = LockLoad;
        end else begin
          timer_d = timer_dec;
        end
      end

      StLockout: begin
        if (admin_clr) begin
          state_d = StIdle;
          timer_d = '0;
          fail_d  = '0;
        end else if (timer_zero) begin
          state_d = StIdle;
          fail_d  = '0;
        end else begin
          timer_d = timer_dec;
        end
      end

      default: begin
        state_d = StIdle;
        timer_d = '0;
        fail_d  = '0;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs track state_q exactly.
  always_comb begin
    unlock_d = (state_d == StOpen);
    alarm_d  = (state_d == StAlarm);
    locked_d = (state_d == StAlarm) || (state_d == StLockout);
  end

  // State, timer, counter and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      fail_q   <= '0;
      unlock_q <= 1'b0;
      alarm_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      fail_q   <= fail_d;
      unlock_q <= unlock_d;
      alarm_q  <= alarm_d;
      locked_q <= locked_d;
    end
  end

  assign unlock     = unlock_q;
  assign alarm      = alarm_q;
  assign locked_out = locked_q;
  assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl with short timers: a vector table for the
// basic open/alarm/lockout flows plus hand sequences for priority and reset cases.
module tb_alarm_ctrl;

  logic       clk;
  logic       rst_n;
  logic       check;
  logic       match;
  logic       close;
  logic       admin_clr;
  logic       unlock;
  logic       alarm;
  logic       locked_out;
  logic [1:0] fail_cnt;

  int total = 0;
  int bad   = 0;

  alarm_ctrl #(
    .MAX_FAILS   (3),
    .OPEN_CYCLES (4),
    .ALARM_CYCLES(8),
    .LOCK_CYCLES (6)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .check     (check),
    .match     (match),
    .close     (close),
    .admin_clr (admin_clr),
    .unlock    (unlock),
    .alarm     (alarm),
    .locked_out(locked_out),
    .fail_cnt  (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs packed as {unlock, alarm, locked_out, fail_cnt}.
  typedef struct {
    logic       chk;
    logic       mat;
    logic       cls;
    logic       adm;
    logic [4:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [4:0] ex(input logic u, input logic a, input logic l,
                                    input logic [1:0] f);
    return {u, a, l, f};
  endfunction

  task automatic add(input logic c, input logic m, input logic cl, input logic a,
                     input logic [4:0] e, input string nm);
    vec_t v;
    v.chk = c; v.mat = m; v.cls = cl; v.adm = a; v.exp = e; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic compare(input string nm, input logic [4:0] req);
    logic [4:0] act;
    act = {unlock, alarm, locked_out, fail_cnt};
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got u/a/l/f=%b/%b/%b/%0d required %b/%b/%b/%0d", nm,
               act[4], act[3], act[2], act[1:0], req[4], req[3], req[2], req[1:0]);
    end
  endtask

  // Drive one cycle of inputs, clock it in, then compare just after the edge.
  task automatic step(input logic c, input logic m, input logic cl, input logic a,
                      input logic [4:0] e, input string nm);
    check = c; match = m; close = cl; admin_clr = a;
    @(posedge clk);
    #1;
    compare(nm, e);
    check = 1'b0; match = 1'b0; close = 1'b0; admin_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; check = 1'b0; match = 1'b0; close = 1'b0; admin_clr = 1'b0;

    // Open: correct code gives exactly four unlocked cycles.
    add(1, 1, 0, 0, ex(1, 0, 0, 0), "open_c1");
    add(0, 0, 0, 0, ex(1, 0, 0, 0), "open_c2");
    add(0, 0, 0, 0, ex(1, 0, 0, 0), "open_c3");
    add(1, 0, 0, 0, ex(1, 0, 0, 0), "open_c4_check_ignored");
    add(0, 0, 0, 0, ex(0, 0, 0, 0), "open_expired");
    // Three wrong codes: alarm 8 cycles, then lockout 6 more.
    add(1, 0, 0, 0, ex(0, 0, 0, 1), "wrong1");
    add(1, 1, 0, 0, ex(0, 0, 0, 1), "wrong1_hold_dontcare");
    vecs[$].chk = 1'b0; // match high without check must be ignored
    add(1, 0, 0, 0, ex(0, 0, 0, 2), "wrong2");
    add(1, 0, 0, 0, ex(0, 1, 1, 3), "alarm_c1");
    for (int i = 2; i <= 8; i++) add(0, 0, 0, 0, ex(0, 1, 1, 3), $sformatf("alarm_c%0d", i));
    add(1, 1, 0, 0, ex(0, 0, 1, 3), "lock_c1_check_ignored");
    for (int i = 2; i <= 5; i++) add(0, 0, 0, 0, ex(0, 0, 1, 3), $sformatf("lock_c%0d", i));
    add(0, 0, 1, 0, ex(0, 0, 1, 3), "lock_c6_close_ignored");
    add(0, 0, 0, 0, ex(0, 0, 0, 0), "lock_done_idle");
    // Two wrong then correct clears the count; a later wrong restarts at 1.
    add(1, 0, 0, 0, ex(0, 0, 0, 1), "mix_wrong1");
    add(1, 0, 0, 0, ex(0, 0, 0, 2), "mix_wrong2");
    add(1, 1, 0, 0, ex(1, 0, 0, 0), "mix_correct");
    add(0, 0, 0, 0, ex(1, 0, 0, 0), "mix_open2");
    add(0, 0, 0, 0, ex(1, 0, 0, 0), "mix_open3");
    add(0, 0, 0, 0, ex(1, 0, 0, 0), "mix_open4");
    add(0, 0, 0, 0, ex(0, 0, 0, 0), "mix_closed");
    add(1, 0, 0, 0, ex(0, 0, 0, 1), "mix_wrong_again");
    add(1, 0, 0, 0, ex(0, 0, 0, 2), "mix_wrong_again2");
    // admin_clr in IDLE clears the count and beats a simultaneous wrong code.
    add(1, 0, 0, 1, ex(0, 0, 0, 0), "idle_admin_clr");
    add(0, 0, 1, 0, ex(0, 0, 0, 0), "idle_close_noop");

    // Asynchronous reset state, checked before any clock edge.
    #3;
    compare("reset_state", ex(0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].chk, vecs[i].mat, vecs[i].cls, vecs[i].adm, vecs[i].exp, vecs[i].name);

    // Alarm ignores code and close; admin_clr in its third cycle returns to IDLE.
    step(1, 0, 0, 0, ex(0, 0, 0, 1), "s35_wrong1");
    step(1, 0, 0, 0, ex(0, 0, 0, 2), "s35_wrong2");
    step(1, 0, 0, 0, ex(0, 1, 1, 3), "s35_alarm");
    step(1, 1, 1, 0, ex(0, 1, 1, 3), "s35_alarm_match_close");
    step(1, 1, 0, 0, ex(0, 1, 1, 3), "s35_alarm_match");
    step(0, 0, 0, 1, ex(0, 0, 0, 0), "s35_admin_clr");
    step(1, 1, 0, 0, ex(1, 0, 0, 0), "s35_idle_then_open");

    // admin_clr ignored in OPEN; close plus wrong code in OPEN relocks without counting.
    step(0, 0, 0, 1, ex(1, 0, 0, 0), "s36_open_admin_ignored");
    step(1, 0, 1, 0, ex(0, 0, 0, 0), "s36_close_with_check");
    step(0, 0, 0, 0, ex(0, 0, 0, 0), "s36_idle");

    // admin_clr coinciding with alarm expiry goes to IDLE, not LOCKOUT.
    step(1, 0, 0, 0, ex(0, 0, 0, 1), "s36b_wrong1");
    step(1, 0, 0, 0, ex(0, 0, 0, 2), "s36b_wrong2");
    step(1, 0, 0, 0, ex(0, 1, 1, 3), "s36b_alarm_c1");
    for (int i = 2; i <= 8; i++) step(0, 0, 0, 0, ex(0, 1, 1, 3), $sformatf("s36b_alarm_c%0d", i));
    step(0, 0, 0, 1, ex(0, 0, 0, 0), "s36b_admin_at_expiry");
    step(0, 0, 0, 0, ex(0, 0, 0, 0), "s36b_stays_idle");

    // Reset pulsed mid-alarm between edges clears everything without a clock.
    step(1, 0, 0, 0, ex(0, 0, 0, 1), "s37_wrong1");
    step(1, 0, 0, 0, ex(0, 0, 0, 2), "s37_wrong2");
    step(1, 0, 0, 0, ex(0, 1, 1, 3), "s37_alarm_c1");
    step(0, 0, 0, 0, ex(0, 1, 1, 3), "s37_alarm_c2");
    #2;
    rst_n = 1'b0;
    #1;
    compare("s37_async_reset", ex(0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, ex(0, 0, 0, 0), "s37_after_release");
    step(1, 0, 0, 0, ex(0, 0, 0, 1), "s37_count_from_zero");
    step(1, 1, 0, 0, ex(1, 0, 0, 0), "s37_open_from_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
